// File: rtl/decode_pkg.sv
// decode_pkg: shared types and constants for the decode stage.
//   - opcode[6:2] class codes
//   - writeback select encodings
//   - decode_t: every decoded field; also the skid-FIFO entry type.
//     imm is carried at 64 bits and truncated to XLEN by the stage.
package decode_pkg;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_IMM32  = 5'b00110;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_REG    = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_REG32  = 5'b01110;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  localparam logic [1:0] WB_NONE = 2'd0;
  localparam logic [1:0] WB_PC4  = 2'd1;
  localparam logic [1:0] WB_ALU  = 2'd2;
  localparam logic [1:0] WB_ALU2 = 2'd3;

  localparam int IMM_W = 64;

  typedef struct packed {
    logic [IMM_W-1:0] imm;
    logic [1:0]       alu_op;
    logic [1:0]       alu2_op;
    logic             alt_op;
    logic             alt2_op;
    logic [4:0]       ra;
    logic [4:0]       rb;
    logic [4:0]       rd;
    logic             sel_pc_a;
    logic             sel_imm_b;
    logic [1:0]       wb;
    logic             mem;
    logic             mem_read;
    logic             branch;
    logic [2:0]       comparison;
    logic             word_op;
    logic             illegal;
    logic             muldiv;
  } decode_t;

  // funct3 values whose result comes from the second ALU (shifts/compares)
  function automatic logic sel_d(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b011) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/decode_logic.sv
// decode_logic: combinational RV32/RV64 instruction decoder.
//   instr : 32-bit instruction word
//   dec   : decoded fields (decode_t), imm sign-extended to 64 bits
// Optional macro DECODE_MULDIV_EN: decode funct7==0x01 R-ops as mul/div
// instead of flagging them illegal.
module decode_logic
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0] instr,
  output decode_t     dec
);

  typedef enum logic [2:0] {C_NONE, C_R, C_I, C_S, C_B, C_U, C_J} cls_e;

  cls_e        cls;
  logic        w_op;
  logic        sd;
  logic        rd_nz;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm32;

  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign sd    = sel_d(f3);
  assign rd_nz = (instr[11:7] != 5'd0);

  // W-opcodes only exist on RV64; on RV32 they fall to C_NONE -> illegal
  always_comb begin
    cls  = C_NONE;
    w_op = 1'b0;
    case (instr[6:2])
      OP_REG:                             cls = C_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: cls = C_I;
      OP_STORE:                           cls = C_S;
      OP_BRANCH:                          cls = C_B;
      OP_LUI, OP_AUIPC:                   cls = C_U;
      OP_JAL:                             cls = C_J;
      OP_REG32: if (XLEN == 64) begin cls = C_R; w_op = 1'b1; end
      OP_IMM32: if (XLEN == 64) begin cls = C_I; w_op = 1'b1; end
      default:  cls = C_NONE;
    endcase
  end

  always_comb begin
    dec          = '0;
    imm32        = '0;
    dec.ra       = instr[19:15];
    dec.rb       = instr[24:20];
    dec.rd       = instr[11:7];
    dec.word_op  = w_op;
    dec.mem      = ({instr[6], instr[4:2]} == 4'b0000);
    dec.mem_read = !instr[5];
    if (cls == C_R || cls == C_I) begin
      dec.alu_op  = {f3[2], f3[1] ^ f3[0]};
      dec.alu2_op = {f3[2], f3[1]};
      dec.wb      = rd_nz ? {1'b1, sd} : WB_NONE;
    end
    case (cls)
      C_R: begin
        dec.sel_imm_b = sd;
        dec.alt_op    = (f7 == 7'h20);
        dec.alt2_op   = (f7 == 7'h20);
`ifdef DECODE_MULDIV_EN
        if (f7 == 7'h01) begin
          dec.muldiv  = 1'b1;
          dec.alu_op  = 2'd0;
          dec.alu2_op = 2'd0;
          dec.wb      = rd_nz ? WB_ALU : WB_NONE;
        end
`endif
      end
      C_I: begin
        dec.sel_imm_b = !sd;
        dec.alt2_op   = instr[30];
        imm32         = {{20{instr[31]}}, instr[31:20]};
      end
      C_S: begin
        dec.sel_imm_b = 1'b1;
        imm32         = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      C_B: begin
        dec.alu2_op    = 2'd1;
        dec.sel_pc_a   = 1'b1;
        dec.branch     = 1'b1;
        dec.comparison = f3;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      C_U: begin
        dec.alu2_op   = 2'd3;
        dec.sel_pc_a  = 1'b1;
        dec.sel_imm_b = !instr[5];
        dec.wb        = rd_nz ? {1'b1, instr[5]} : WB_NONE;
        imm32         = {instr[31:12], 12'b0};
      end
      C_J: begin
        dec.sel_pc_a  = 1'b1;
        dec.sel_imm_b = 1'b1;
        dec.branch    = 1'b1;
        dec.wb        = rd_nz ? WB_PC4 : WB_NONE;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: ;
    endcase
    dec.imm = {{(IMM_W-32){imm32[31]}}, imm32};

    dec.illegal = (instr[1:0] != 2'b11) || (cls == C_NONE);
`ifndef DECODE_MULDIV_EN
    if (cls == C_R && f7 == 7'h01) dec.illegal = 1'b1;
`endif
    // illegal entries still flow, but must not write back, touch memory or redirect
    if (dec.illegal) begin
      dec.wb     = WB_NONE;
      dec.mem    = 1'b0;
      dec.branch = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode stage, decode_logic in front of a
// 2-entry skid FIFO. in_ready depends only on the entry count, never on
// out_ready. Outputs are the head entry; don't-care while out_valid=0.
//   clk/rst_n        : clock, async active-low reset
//   flush            : drop all buffered and same-cycle incoming entries
//   in_*             : fetch side valid/ready, instruction, pc
//   out_valid/ready  : execute side handshake; out_pc + decoded fields
// Optional macro DECODE_MULDIV_EN adds the muldiv output.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [XLEN-1:0] imm,
  output logic [1:0]      alu_op,
  output logic [1:0]      alu2_op,
  output logic            alt_op,
  output logic            alt2_op,
  output logic [4:0]      ra,
  output logic [4:0]      rb,
  output logic [4:0]      rd,
  output logic            sel_pc_a,
  output logic            sel_imm_b,
  output logic [1:0]      wb,
  output logic            mem,
  output logic            mem_read,
  output logic            branch,
  output logic [2:0]      comparison,
  output logic            word_op,
`ifdef DECODE_MULDIV_EN
  output logic            muldiv,
`endif
  output logic            illegal
);

  decode_t         dec_in;
  decode_t         ent_q  [2];
  decode_t         ent_d  [2];
  logic [PC_W-1:0] pc_q   [2];
  logic [PC_W-1:0] pc_d   [2];
  logic            rd_ptr_q, rd_ptr_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            push, pop;
  decode_t         head;
  logic            unused_head;

  decode_logic #(.XLEN(XLEN)) u_dec (
    .instr (in_instr),
    .dec   (dec_in)
  );

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    ent_d    = ent_q;
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (push) begin
        ent_d[wr_ptr_q] = dec_in;
        pc_d[wr_ptr_q]  = in_pc;
        wr_ptr_d        = !wr_ptr_q;
      end
      if (pop) rd_ptr_d = !rd_ptr_q;
      cnt_d = cnt_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        ent_q[i] <= '0;
        pc_q[i]  <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      ent_q    <= ent_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head       = ent_q[rd_ptr_q];
  assign out_pc     = pc_q[rd_ptr_q];
  assign imm        = head.imm[XLEN-1:0];
  assign alu_op     = head.alu_op;
  assign alu2_op    = head.alu2_op;
  assign alt_op     = head.alt_op;
  assign alt2_op    = head.alt2_op;
  assign ra         = head.ra;
  assign rb         = head.rb;
  assign rd         = head.rd;
  assign sel_pc_a   = head.sel_pc_a;
  assign sel_imm_b  = head.sel_imm_b;
  assign wb         = head.wb;
  assign mem        = head.mem;
  assign mem_read   = head.mem_read;
  assign branch     = head.branch;
  assign comparison = head.comparison;
  assign word_op    = head.word_op;
  assign illegal    = head.illegal;
`ifdef DECODE_MULDIV_EN
  assign muldiv     = head.muldiv;
`endif
  // upper imm bits (XLEN=32) and muldiv (feature off) have no port
  assign unused_head = ^{head.imm, head.muldiv};

endmodule
